risc_loader: RTL and testbench

RISC_LOADER -- requirements
Module: risc_loader

---
 rtl/risc_pkg.sv | 11 +
 rtl/risc_loader_if.sv | 13 +
 rtl/risc_loader_instr_mem.sv | 25 ++
 rtl/risc_loader.sv | 73 +++++++
 tb/tb_risc_loader.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared state encodings, default NOP and address-width helpers for the loader
package risc_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, HALT = 3'd3, STEP = 3'd4} state_t;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
  function automatic int aw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int ba_w(input int xlen, input int depth);
    return aw(depth * (xlen / 8));
  endfunction
endpackage

// File: rtl/risc_loader_if.sv
// risc_loader_if: byte-load handshake and core instruction-fetch port
interface risc_loader_if import risc_pkg::*; #(parameter int XLEN = 32, parameter int DEPTH = 32);
  localparam int IA_W = aw(DEPTH);
  localparam int BA_W = ba_w(XLEN, DEPTH);
  logic ld_valid;
  logic ld_ready;
  logic [BA_W-1:0] ld_addr;
  logic [7:0] ld_data;
  logic [IA_W-1:0] fetch_addr;
  logic [XLEN-1:0] fetch_data;
  modport master(output ld_valid, ld_addr, ld_data, fetch_addr, input ld_ready, fetch_data);
  modport slave(input ld_valid, ld_addr, ld_data, fetch_addr, output ld_ready, fetch_data);
endinterface

// File: rtl/risc_loader_instr_mem.sv
// instr_mem: byte-lane write, registered word read returning NOP beyond DEPTH
module instr_mem import risc_pkg::*; #(
  parameter int XLEN = 32,
  parameter int DEPTH = 32,
  parameter logic [31:0] NOP_INSN = NOP_DEFAULT,
  localparam int IA_W = aw(DEPTH),
  localparam int LN_W = aw(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IA_W-1:0] waddr,
  input  logic [LN_W-1:0] wlane,
  input  logic [7:0]      wdata,
  input  logic [IA_W-1:0] raddr,
  output logic [XLEN-1:0] rdata
);
  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSN);
  logic [XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr][{wlane, 3'b000} +: 8] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else rdata <= ({1'b0, raddr} < (IA_W + 1)'(DEPTH)) ? mem[raddr] : NOP;
endmodule

// File: rtl/risc_loader.sv
// risc_loader: byte loader into instruction memory plus run/halt/step control of the core
module risc_loader import risc_pkg::*; #(
  parameter int XLEN = 32,
  parameter int DEPTH = 32,
  parameter int CNT_W = 16,
  parameter int RUN_LIMIT = 0,
  parameter logic [31:0] NOP_INSN = NOP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  risc_loader_if.slave     bus,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_step,
  output logic             core_en,
  output logic             core_rst_n,
  output state_t           state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             load_err,
  output logic             timeout
);
  localparam int BPW = XLEN / 8;
  localparam int IA_W = aw(DEPTH);
  localparam int LN_W = aw(BPW);
  state_t nxt;
  logic [31:0] widx;
  logic in_rng, acc, wd_hit, fresh;
  logic [CNT_W-1:0] cnt_nxt;
  assign bus.ld_ready = state inside {IDLE, LOAD, HALT};
  assign acc = bus.ld_valid && bus.ld_ready;
  assign widx = 32'(bus.ld_addr) / BPW;
  assign in_rng = widx < 32'(DEPTH);
  assign cnt_nxt = &cycle_cnt ? cycle_cnt : cycle_cnt + 1'b1;
  // trips on the edge where the count reaches the limit, so exactly RUN_LIMIT enabled cycles run
  assign wd_hit = (RUN_LIMIT != 0) && state == RUN && cnt_nxt >= CNT_W'(RUN_LIMIT);
  assign fresh = nxt == RUN && state inside {IDLE, LOAD};
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = cmd_run ? RUN : acc ? LOAD : IDLE;
      LOAD:    nxt = cmd_run ? RUN : LOAD;
      RUN:     nxt = (cmd_halt || wd_hit) ? HALT : RUN;
      HALT:    nxt = cmd_halt ? HALT : cmd_step ? STEP : cmd_run ? RUN : acc ? LOAD : HALT;
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      core_en    <= 1'b0;
      core_rst_n <= 1'b0;
      cycle_cnt  <= '0;
      load_err   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= nxt;
      core_en    <= nxt inside {RUN, STEP};
      core_rst_n <= nxt inside {RUN, HALT, STEP};
      cycle_cnt  <= (nxt == LOAD || fresh) ? '0 : core_en ? cnt_nxt : cycle_cnt;
      load_err   <= (acc && !in_rng) || (load_err && !fresh);
      timeout    <= wd_hit || (timeout && !fresh);
    end
  instr_mem #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSN(NOP_INSN)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (acc && in_rng),
    .waddr (IA_W'(widx)),
    .wlane (LN_W'(32'(bus.ld_addr) % BPW)),
    .wdata (bus.ld_data),
    .raddr (bus.fetch_addr),
    .rdata (bus.fetch_data)
  );
endmodule

// File: tb/tb_risc_loader.sv
// tb_risc_loader: directed stimulus with queued expectations checked by a separate monitor
module tb_risc_loader;
  import risc_pkg::*;
  localparam int S_ST = 0, S_EN = 1, S_RN = 2, S_CC = 3, S_LE = 4, S_TO = 5, S_FD = 6, S_RDY = 7;
  typedef struct {int due; bit d; int sel; logic [31:0] v; string nm;} exp_t;
  logic clk = 0, rst_n = 0;
  logic ra, ha, sa, rb, hb, sb;
  logic cea, cra, lea, toa, ceb, crb, leb, tob;
  logic [2:0] sta, stb;
  logic [15:0] cca, ccb;
  exp_t q[$];
  int edges = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  risc_loader_if #(.XLEN(32), .DEPTH(20)) ia();
  risc_loader_if #(.XLEN(32), .DEPTH(32)) ib();
  risc_loader #(.DEPTH(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .cmd_run(ra), .cmd_halt(ha), .cmd_step(sa),
    .core_en(cea), .core_rst_n(cra), .state(sta), .cycle_cnt(cca), .load_err(lea), .timeout(toa));
  risc_loader #(.DEPTH(32), .RUN_LIMIT(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .cmd_run(rb), .cmd_halt(hb), .cmd_step(sb),
    .core_en(ceb), .core_rst_n(crb), .state(stb), .cycle_cnt(ccb), .load_err(leb), .timeout(tob));
  always @(posedge clk) edges <= edges + 1;
  function automatic logic [31:0] probe(bit d, int sel);
    case (sel)
      S_ST:    return d ? 32'(stb) : 32'(sta);
      S_EN:    return d ? 32'(ceb) : 32'(cea);
      S_RN:    return d ? 32'(crb) : 32'(cra);
      S_CC:    return d ? 32'(ccb) : 32'(cca);
      S_LE:    return d ? 32'(leb) : 32'(lea);
      S_TO:    return d ? 32'(tob) : 32'(toa);
      S_FD:    return d ? ib.fetch_data : ia.fetch_data;
      default: return d ? 32'(ib.ld_ready) : 32'(ia.ld_ready);
    endcase
  endfunction
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    logic [31:0] got;
    #1;
    while (q.size() > 0 && q[0].due <= edges) begin
      e = q.pop_front();
      got = probe(e.d, e.sel);
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s dut_%s got %h want %h", e.nm, e.d ? "b" : "a", got, e.v);
      end
    end
  end
  task automatic push(int due, bit d, int sel, logic [31:0] v, string nm);
    exp_t e;
    e.due = due; e.d = d; e.sel = sel; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask
  task automatic ex(bit d, int sel, logic [31:0] v, string nm);
    push(edges + 1, d, sel, v, nm);
  endtask
  task automatic ex_now(bit d, int sel, logic [31:0] v, string nm);
    push(edges, d, sel, v, nm);
  endtask
  task automatic drv_ld(bit d, int a, logic [7:0] v);
    if (d) begin ib.ld_valid = 1; ib.ld_addr = 7'(a); ib.ld_data = v; end
    else begin ia.ld_valid = 1; ia.ld_addr = 7'(a); ia.ld_data = v; end
  endtask
  task automatic step();
    @(negedge clk);
    {ra, ha, sa, rb, hb, sb} = '0;
    ia.ld_valid = 0;
    ib.ld_valid = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL sim_timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] w0 [4] = '{8'h13, 8'h05, 8'h10, 8'h00};
    logic [7:0] w1 [4] = '{8'hef, 8'hbe, 8'had, 8'hde};
    {ra, ha, sa, rb, hb, sb} = '0;
    ia.ld_valid = 0; ia.ld_addr = 0; ia.ld_data = 0; ia.fetch_addr = 0;
    ib.ld_valid = 0; ib.ld_addr = 0; ib.ld_data = 0; ib.fetch_addr = 0;
    repeat (2) @(negedge clk);
    ex(0, S_ST, 0, "rst_state"); ex(0, S_EN, 0, "rst_en"); ex(0, S_RN, 0, "rst_core_rst");
    ex(0, S_CC, 0, "rst_cnt"); ex(0, S_LE, 0, "rst_err"); ex(0, S_TO, 0, "rst_to");
    ex(0, S_FD, 0, "rst_fetch"); ex(0, S_RDY, 1, "rst_ready");
    step();
    #2 rst_n = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      drv_ld(0, i, w0[i]);
      if (i == 0) ex(0, S_ST, 1, "idle_to_load");
      step();
    end
    for (int i = 0; i < 4; i++) begin drv_ld(0, 4 + i, w1[i]); step(); end
    drv_ld(0, 6, 8'h77); step();
    ia.fetch_addr = 0;
    ex(0, S_FD, 32'h00100513, "fetch_w0"); ex(0, S_ST, 1, "state_load"); ex(0, S_RDY, 1, "load_ready");
    step();
    ia.fetch_addr = 1; ex(0, S_FD, 32'hde77beef, "fetch_w1_lane"); step();
    ha = 1; sa = 1; ex(0, S_ST, 1, "cmd_ign_load"); ex(0, S_EN, 0, "en_ign_load"); step();
    drv_ld(0, 80, 8'haa); ia.fetch_addr = 20;
    ex(0, S_LE, 1, "oor_err"); ex(0, S_FD, 32'h13, "fetch_nop20"); step();
    drv_ld(0, 127, 8'h55); ia.fetch_addr = 0; ex(0, S_FD, 32'h00100513, "w0_after_oor"); step();
    ia.fetch_addr = 31; ex(0, S_FD, 32'h13, "fetch_nop31"); ex(0, S_LE, 1, "err_sticky"); step();
    ia.fetch_addr = 1; ex(0, S_FD, 32'hde77beef, "w1_after_oor"); step();
    ra = 1;
    ex(0, S_ST, 2, "run_state"); ex(0, S_EN, 1, "run_en"); ex(0, S_RN, 1, "run_core_rst");
    ex(0, S_LE, 0, "run_clr_err"); ex(0, S_CC, 0, "run_cnt0"); ex(0, S_RDY, 0, "run_not_ready");
    step();
    repeat (9) step();
    ha = 1;
    ex(0, S_ST, 3, "halt_state"); ex(0, S_CC, 10, "halt_cnt10"); ex(0, S_EN, 0, "halt_en");
    ex(0, S_RN, 1, "halt_core_rst"); ex(0, S_RDY, 1, "halt_ready");
    step();
    ex(0, S_CC, 10, "halt_cnt_held"); step();
    for (int k = 0; k < 3; k++) begin
      sa = 1;
      if (k == 2) ra = 1;
      ex(0, S_ST, 4, "step_state"); ex(0, S_EN, 1, "step_en");
      step();
      if (k == 1) ra = 1;
      ex(0, S_ST, 3, "step_back"); ex(0, S_EN, 0, "step_en_off"); ex(0, S_CC, 11 + k, "step_cnt");
      step();
    end
    ha = 1; sa = 1; ra = 1; ex(0, S_ST, 3, "halt_prio"); ex(0, S_CC, 13, "prio_cnt"); step();
    ra = 1; ex(0, S_ST, 2, "rerun"); ex(0, S_CC, 13, "rerun_keep_cnt"); step();
    ha = 1; ex(0, S_ST, 3, "rehalt"); ex(0, S_CC, 14, "rehalt_cnt"); step();
    drv_ld(0, 0, 8'h13);
    ex(0, S_ST, 1, "halt_to_load"); ex(0, S_CC, 0, "load_clr_cnt"); ex(0, S_RN, 0, "load_core_rst");
    step();
    drv_ld(0, 3, 8'h01); ra = 1; ex(0, S_ST, 2, "byte_and_run"); step();
    ia.fetch_addr = 0; ex(0, S_FD, 32'h01100513, "byte_run_written"); step();
    drv_ld(1, 0, 8'h13); ex(1, S_ST, 1, "b_load"); step();
    rb = 1; ex(1, S_ST, 2, "b_run"); ex(1, S_TO, 0, "b_to0"); step();
    for (int i = 1; i < 5; i++) begin
      ex(1, S_ST, 2, "b_running"); ex(1, S_CC, i, "b_cnt"); step();
    end
    ex(1, S_ST, 3, "b_wd_halt"); ex(1, S_TO, 1, "b_timeout"); ex(1, S_CC, 5, "b_wd_cnt"); step();
    ex(1, S_ST, 3, "b_halt_hold"); ex(1, S_CC, 5, "b_cnt_hold"); step();
    rb = 1; ex(1, S_ST, 2, "b_rerun"); step();
    ex(1, S_ST, 3, "b_rewd"); ex(1, S_CC, 6, "b_rewd_cnt"); ex(1, S_TO, 1, "b_rewd_to"); step();
    drv_ld(1, 1, 8'h00);
    ex(1, S_ST, 1, "b_halt_load"); ex(1, S_CC, 0, "b_load_cnt"); ex(1, S_TO, 1, "b_to_sticky");
    step();
    rb = 1; ex(1, S_ST, 2, "b_run2"); ex(1, S_TO, 0, "b_to_clear"); step();
    #2;
    ex_now(0, S_ST, 0, "arst_state"); ex_now(0, S_EN, 0, "arst_en"); ex_now(0, S_RN, 0, "arst_core_rst");
    ex_now(0, S_CC, 0, "arst_cnt"); ex_now(0, S_FD, 0, "arst_fetch"); ex_now(0, S_TO, 0, "arst_to");
    rst_n = 0;
    @(negedge clk);
    ex(0, S_ST, 0, "rst_hold");
    #2 rst_n = 1;
    ia.fetch_addr = 1; ex(0, S_FD, 32'hde77beef, "mem_kept_w1"); step();
    ia.fetch_addr = 0; ex(0, S_FD, 32'h01100513, "mem_kept_w0"); step();
    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
